// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and address map for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] RAM_REGION = 16'h1001;
  localparam logic [15:0] IO_REGION  = 16'h1003;
  localparam logic [3:0]  LED_OFS    = 4'h0;
  localparam logic [3:0]  CNT_OFS    = 4'h4;

  // Wait-state counter width; covers WAIT_CYCLES up to 15.
  localparam int CW = 4;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - processor data-memory bus between datapath (master) and responder (slave)
interface dmem_if #(
  parameter int Dbits = 32
);

  logic             mem_req;
  logic             mem_wr;
  logic [Dbits-1:0] mem_addr;
  logic [Dbits-1:0] mem_writedata;
  logic [Dbits-1:0] mem_readdata;
  logic             stall;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_writedata,
    input  mem_readdata, stall
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_writedata,
    output mem_readdata, stall
  );

endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port data RAM, synchronous write and asynchronous read
module dmem_ram #(
  parameter int Nloc  = 64,
  parameter int Dbits = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(Nloc)-1:0] addr,
  input  logic [Dbits-1:0]        wdata,
  output logic [Dbits-1:0]        rdata
);

  logic [Dbits-1:0] mem [Nloc];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state FSM, address decode, LED and cycle-counter registers
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          Nloc        = 64,
  parameter int          Dbits       = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RAM_BASE    = {RAM_REGION, 16'h0000},
  parameter logic [31:0] IO_BASE     = {IO_REGION, 16'h0000}
) (
  input  logic             clk,
  input  logic             reset,
  dmem_if.slave            bus,
  output logic [15:0]      led,
  output logic [Dbits-1:0] cycle_count
);

  localparam int AW = $clog2(Nloc);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [Dbits-1:0] addr_q;
  logic [Dbits-1:0] wdata_q;
  logic             wr_q;
  logic [Dbits-1:0] rdata_q;
  logic [15:0]      led_q;
  logic [Dbits-1:0] cyc_q;
  logic [Dbits-1:0] cyc_d;

  // Decode the live address only in IDLE (zero-wait capture); otherwise the latched copy.
  logic [Dbits-1:0] acc_addr;
  logic [15:0]      io_ofs;
  logic             is_ram;
  logic             is_io;
  logic             is_led;
  logic             is_cnt;
  logic [Dbits-1:0] ram_rdata;
  logic [Dbits-1:0] rd_val;
  logic             ram_we;
  logic             led_we;
  logic             commit;
  logic             unused_addr_bits;

  assign acc_addr = (state_q == IDLE) ? bus.mem_addr : addr_q;
  assign io_ofs   = {acc_addr[15:2], 2'b00};
  assign is_ram   = (acc_addr[31:16] == RAM_BASE[31:16]);
  assign is_io    = (acc_addr[31:16] == IO_BASE[31:16]);
  assign is_led   = is_io && (io_ofs == 16'(LED_OFS));
  assign is_cnt   = is_io && (io_ofs == 16'(CNT_OFS));

  assign unused_addr_bits = ^acc_addr[1:0];

  always_comb begin
    rd_val = '0;
    if (is_ram) begin
      rd_val = ram_rdata;
    end else if (is_led) begin
      rd_val = {{(Dbits-16){1'b0}}, led_q};
    end else if (is_cnt) begin
      rd_val = cyc_q;
    end
  end

  // A store lands only if the request is still held through DONE.
  assign commit = (state_q == DONE) && bus.mem_req && wr_q;
  assign ram_we = commit && is_ram;
  assign led_we = commit && is_led;

  dmem_ram #(
    .Nloc  (Nloc),
    .Dbits (Dbits)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (acc_addr[AW+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.mem_req) begin
            addr_q  <= bus.mem_addr;
            wr_q    <= bus.mem_wr;
            wdata_q <= bus.mem_writedata;
            if (WAIT_CYCLES == 0) begin
              state_q <= DONE;
              rdata_q <= rd_val;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (!bus.mem_req) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q <= DONE;
            rdata_q <= rd_val;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (led_we) begin
            led_q <= wdata_q[15:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cyc_d = cyc_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  // Reset gates stall so a frozen datapath is released the moment reset asserts.
  assign bus.stall        = bus.mem_req && (state_q != DONE) && !reset;
  assign bus.mem_readdata = (state_q == DONE) ? rdata_q : '0;
  assign led              = led_q;
  assign cycle_count      = cyc_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - vector table plus scoreboard bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] led_a, led_b;
  logic [31:0] cc_a, cc_b;
  logic [31:0] tb_cnt;
  int          wr_cnt_a = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] sb_q [$];

  dmem_if a_if ();
  dmem_if b_if ();

  dmem_responder #(.WAIT_CYCLES(2)) u_a (
    .clk (clk), .reset (reset), .bus (a_if), .led (led_a), .cycle_count (cc_a)
  );

  dmem_responder #(.WAIT_CYCLES(0)) u_b (
    .clk (clk), .reset (reset), .bus (b_if), .led (led_b), .cycle_count (cc_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 32'd0;
    else       tb_cnt <= tb_cnt + 32'd1;
  end

  always @(posedge clk) begin
    if (u_a.ram_we === 1'b1) wr_cnt_a <= wr_cnt_a + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        is_cnt;
    logic [15:0] led;
    int          wcnt;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input bit sel, input logic req, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel) begin
      b_if.mem_req = req; b_if.mem_wr = wr; b_if.mem_addr = addr; b_if.mem_writedata = wd;
    end else begin
      a_if.mem_req = req; a_if.mem_wr = wr; a_if.mem_addr = addr; a_if.mem_writedata = wd;
    end
  endtask

  function automatic logic get_stall(input bit sel);
    return sel ? b_if.stall : a_if.stall;
  endfunction

  function automatic logic [31:0] get_rd(input bit sel);
    return sel ? b_if.mem_readdata : a_if.mem_readdata;
  endfunction

  // Called at #1 after a posedge; returns at #1 after the DONE->IDLE edge with mem_req still high.
  task automatic access(input bit sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_stall);
    int          n;
    bit          done;
    logic [31:0] exp;
    if (!wr) sb_q.push_back(exp_rd);
    drive(sel, 1'b1, wr, addr, wd);
    n = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (get_stall(sel)) begin
        n++;
        @(posedge clk);
        #1;
        drive(sel, 1'b1, 1'($urandom), $urandom, $urandom);
      end else begin
        done = 1;
      end
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    if (!wr) begin
      exp = sb_q.pop_front();
      if (done) chk("rdata", get_rd(sel), exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          wc0;
    logic [31:0] exp_rd;
    logic [31:0] t0;

    vt[0]  = '{1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0,         1'b0, 16'h0000, 1};
    vt[1]  = '{1'b0, 32'h1001_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 16'h0000, 0};
    vt[2]  = '{1'b1, 32'h1001_000C, 32'h1234_5678, 32'h0,         1'b0, 16'h0000, 1};
    vt[3]  = '{1'b0, 32'h1001_010C, 32'h0,         32'h1234_5678, 1'b0, 16'h0000, 0};
    vt[4]  = '{1'b1, 32'h1001_0000, 32'h1111_2222, 32'h0,         1'b0, 16'h0000, 1};
    vt[5]  = '{1'b1, 32'h1003_0000, 32'h0001_A5A5, 32'h0,         1'b0, 16'hA5A5, 0};
    vt[6]  = '{1'b0, 32'h1003_0000, 32'h0,         32'h0000_A5A5, 1'b0, 16'hA5A5, 0};
    vt[7]  = '{1'b0, 32'h1003_0002, 32'h0,         32'h0000_A5A5, 1'b0, 16'hA5A5, 0};
    vt[8]  = '{1'b1, 32'h1003_0004, 32'hFFFF_FFFF, 32'h0,         1'b0, 16'hA5A5, 0};
    vt[9]  = '{1'b0, 32'h1003_0004, 32'h0,         32'h0,         1'b1, 16'hA5A5, 0};
    vt[10] = '{1'b0, 32'h1003_0008, 32'h0,         32'h0,         1'b0, 16'hA5A5, 0};
    vt[11] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b0, 16'hA5A5, 0};
    vt[12] = '{1'b1, 32'h0000_1000, 32'h5555_5555, 32'h0,         1'b0, 16'hA5A5, 0};
    vt[13] = '{1'b0, 32'h1001_0000, 32'h0,         32'h1111_2222, 1'b0, 16'hA5A5, 0};
    vt[14] = '{1'b1, 32'h1003_0010, 32'h0000_0077, 32'h0,         1'b0, 16'hA5A5, 0};
    vt[15] = '{1'b0, 32'h1001_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 16'hA5A5, 0};

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(a_if.stall), 32'd0);
    chk("rst_led", 32'(led_a), 32'd0);
    chk("rst_rdata", a_if.mem_readdata, 32'd0);
    chk("rst_cycle_count", cc_a, 32'd0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("count_after_reset", cc_a, 32'(i));
      chk("idle_stall", 32'(a_if.stall), 32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      wc0 = wr_cnt_a;
      exp_rd = vt[i].is_cnt ? tb_cnt + 32'd2 : vt[i].rd;
      access(0, vt[i].wr, vt[i].addr, vt[i].wd, exp_rd, 3);
      chk($sformatf("v%0d_led", i), 32'(led_a), 32'(vt[i].led));
      chk($sformatf("v%0d_ram_writes", i), 32'(wr_cnt_a - wc0), 32'(vt[i].wcnt));
      chk($sformatf("v%0d_cycle_count", i), cc_a, tb_cnt);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    access(0, 1'b1, 32'h1001_0010, 32'hAAAA_0000, 32'h0, 3);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    wc0 = wr_cnt_a;
    drive(0, 1'b1, 1'b1, 32'h1001_0010, 32'hBBBB_0000);
    @(negedge clk);
    chk("pre_abort_stall", 32'(a_if.stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_mid_stall", 32'(a_if.stall), 32'd0);
    chk("reset_mid_led", 32'(led_a), 32'd0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    access(0, 1'b0, 32'h1001_0010, 32'h0, 32'hAAAA_0000, 3);
    chk("reset_mid_ram_writes", 32'(wr_cnt_a - wc0), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

    access(1, 1'b1, 32'h1001_0004, 32'hCAFE_0001, 32'h0, 1);
    access(1, 1'b1, 32'h1001_0008, 32'hCAFE_0002, 32'h0, 1);
    t0 = tb_cnt;
    access(1, 1'b0, 32'h1001_0004, 32'h0, 32'hCAFE_0001, 1);
    access(1, 1'b0, 32'h1001_0008, 32'h0, 32'hCAFE_0002, 1);
    chk("b2b_cycles", tb_cnt - t0, 32'd4);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b_led_untouched", 32'(led_b), 32'd0);
    chk("b_cycle_count", cc_b, tb_cnt);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
